// File: rtl/mac_sched_pkg.sv
// Shared types and default sizes for the MAC buffer scheduler.
package mac_sched_pkg;

  // Batch life cycle: fill the buffer, wait until it is readable, kick readout, drain results.
  typedef enum logic [1:0] {
    StFill    = 2'd0,
    StWaitRd  = 2'd1,
    StIssueRd = 2'd2,
    StCollect = 2'd3
  } sched_state_e;

  localparam int unsigned BatchDefault = 64;
  localparam int unsigned DwDefault    = 16;
  localparam int unsigned RwDefault    = 34;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a single priority pointer bit.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // ptr_q=1 means requester 1 wins a tie.
  logic ptr_q, ptr_d;

  // Grant decode and pointer update: the pointer moves to the side that just lost.
  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
      if (gnt_o[0]) begin
        ptr_d = 1'b1;
      end else if (gnt_o[1]) begin
        ptr_d = 1'b0;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mac_buff_sched.sv
// Schedules dot-product jobs from two requesters into a MAC buffer, then drains the
// batch back out, tagging each result with its slot index and originating requester.
module mac_buff_sched
  import mac_sched_pkg::*;
#(
  parameter int unsigned BATCH = BatchDefault,
  parameter int unsigned DW    = DwDefault,
  parameter int unsigned RW    = RwDefault
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [4*DW-1:0]          req0_vect_a,
  input  logic [4*DW-1:0]          req0_vect_b,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [4*DW-1:0]          req1_vect_a,
  input  logic [4*DW-1:0]          req1_vect_b,
  output logic                     EN_mac,
  input  logic                     RDY_mac,
  output logic [DW-1:0]            mac_vectA_0,
  output logic [DW-1:0]            mac_vectA_1,
  output logic [DW-1:0]            mac_vectA_2,
  output logic [DW-1:0]            mac_vectA_3,
  output logic [DW-1:0]            mac_vectB_0,
  output logic [DW-1:0]            mac_vectB_1,
  output logic [DW-1:0]            mac_vectB_2,
  output logic [DW-1:0]            mac_vectB_3,
  output logic                     EN_blockRead,
  input  logic                     RDY_blockRead,
  input  logic                     VALID_memVal,
  input  logic [RW-1:0]            memVal_data,
  output logic                     res_valid,
  output logic [RW-1:0]            res_data,
  output logic                     res_owner,
  output logic [$clog2(BATCH)-1:0] res_idx,
  output logic                     batch_done,
  output logic                     err_spurious
);

  localparam int unsigned IW = $clog2(BATCH);
  localparam logic [IW-1:0] LastSlot = IW'(BATCH - 1);

  sched_state_e   state_q, state_d;
  logic [IW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [IW-1:0]  rd_cnt_q, rd_cnt_d;
  logic [BATCH-1:0] owner_q, owner_d;
  logic           res_valid_q, res_valid_d;
  logic [RW-1:0]  res_data_q, res_data_d;
  logic           res_owner_q, res_owner_d;
  logic [IW-1:0]  res_idx_q, res_idx_d;
  logic           batch_done_q, batch_done_d;
  logic           err_q, err_d;

  logic           arb_en;
  logic [1:0]     gnt;
  logic           fire;
  logic [4*DW-1:0] sel_a, sel_b;

  // Grants only while filling; gated by reset so handshakes drop the moment reset asserts.
  assign arb_en = RST_N && (state_q == StFill) && RDY_mac;

  rr_arb2 u_arb (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .req_i  ({req1_valid, req0_valid}),
    .en_i   (arb_en),
    .gnt_o  (gnt)
  );

  // Combinational issue path: the granted job goes straight to the MAC buffer.
  always_comb begin
    fire       = |gnt;
    req0_ready = gnt[0];
    req1_ready = gnt[1];
    EN_mac     = fire;
    sel_a      = gnt[1] ? req1_vect_a : req0_vect_a;
    sel_b      = gnt[1] ? req1_vect_b : req0_vect_b;
  end

  assign mac_vectA_0 = sel_a[0*DW +: DW];
  assign mac_vectA_1 = sel_a[1*DW +: DW];
  assign mac_vectA_2 = sel_a[2*DW +: DW];
  assign mac_vectA_3 = sel_a[3*DW +: DW];
  assign mac_vectB_0 = sel_b[0*DW +: DW];
  assign mac_vectB_1 = sel_b[1*DW +: DW];
  assign mac_vectB_2 = sel_b[2*DW +: DW];
  assign mac_vectB_3 = sel_b[3*DW +: DW];

  assign EN_blockRead = RST_N && (state_q == StIssueRd);
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_owner    = res_owner_q;
  assign res_idx      = res_idx_q;
  assign batch_done   = batch_done_q;
  assign err_spurious = err_q;

  // Next-state: batch FSM, slot/read counters, owner bitmap and result registers.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    owner_d      = owner_q;
    res_valid_d  = 1'b0;
    res_data_d   = res_data_q;
    res_owner_d  = res_owner_q;
    res_idx_d    = res_idx_q;
    batch_done_d = 1'b0;
    err_d        = err_q;

    if (VALID_memVal && (state_q != StCollect)) begin
      err_d = 1'b1;
    end

    case (state_q)
      StFill: begin
        if (fire) begin
          owner_d[wr_cnt_q] = gnt[1];
          if (wr_cnt_q == LastSlot) begin
            // Count stays at the last slot until the drain finishes and clears it.
            state_d = StWaitRd;
          end else begin
            wr_cnt_d = wr_cnt_q + IW'(1);
          end
        end
      end
      StWaitRd: begin
        if (RDY_blockRead) begin
          state_d = StIssueRd;
        end
      end
      StIssueRd: begin
        state_d = StCollect;
      end
      StCollect: begin
        if (VALID_memVal) begin
          res_valid_d = 1'b1;
          res_data_d  = memVal_data;
          res_idx_d   = rd_cnt_q;
          res_owner_d = owner_q[rd_cnt_q];
          if (rd_cnt_q == LastSlot) begin
            batch_done_d = 1'b1;
            rd_cnt_d     = '0;
            wr_cnt_d     = '0;
            state_d      = StFill;
          end else begin
            rd_cnt_d = rd_cnt_q + IW'(1);
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  // State registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= StFill;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      owner_q      <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_owner_q  <= 1'b0;
      res_idx_q    <= '0;
      batch_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      owner_q      <= owner_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_owner_q  <= res_owner_d;
      res_idx_q    <= res_idx_d;
      batch_done_q <= batch_done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_mac_buff_sched.sv
// Bench for mac_buff_sched: directed scenarios plus random traffic against a queue-based model.
module tb_mac_buff_sched;

  localparam int BATCH = 64;
  localparam int DW    = 16;
  localparam int RW    = 34;
  localparam int IW    = 6;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            req0_ready, req1_ready;
  logic [4*DW-1:0] req0_vect_a = '0, req0_vect_b = '0, req1_vect_a = '0, req1_vect_b = '0;
  logic            EN_mac;
  logic            RDY_mac = 1'b0;
  logic [DW-1:0]   mac_vectA_0, mac_vectA_1, mac_vectA_2, mac_vectA_3;
  logic [DW-1:0]   mac_vectB_0, mac_vectB_1, mac_vectB_2, mac_vectB_3;
  logic            EN_blockRead;
  logic            RDY_blockRead = 1'b0;
  logic            VALID_memVal = 1'b0;
  logic [RW-1:0]   memVal_data = '0;
  logic            res_valid;
  logic [RW-1:0]   res_data;
  logic            res_owner;
  logic [IW-1:0]   res_idx;
  logic            batch_done;
  logic            err_spurious;

  mac_buff_sched #(.BATCH(BATCH), .DW(DW), .RW(RW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_vect_a(req0_vect_a), .req0_vect_b(req0_vect_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_vect_a(req1_vect_a), .req1_vect_b(req1_vect_b),
    .EN_mac(EN_mac), .RDY_mac(RDY_mac),
    .mac_vectA_0(mac_vectA_0), .mac_vectA_1(mac_vectA_1),
    .mac_vectA_2(mac_vectA_2), .mac_vectA_3(mac_vectA_3),
    .mac_vectB_0(mac_vectB_0), .mac_vectB_1(mac_vectB_1),
    .mac_vectB_2(mac_vectB_2), .mac_vectB_3(mac_vectB_3),
    .EN_blockRead(EN_blockRead), .RDY_blockRead(RDY_blockRead),
    .VALID_memVal(VALID_memVal), .memVal_data(memVal_data),
    .res_valid(res_valid), .res_data(res_data), .res_owner(res_owner), .res_idx(res_idx),
    .batch_done(batch_done), .err_spurious(err_spurious)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 filling, 1 waiting for readable buffer, 2 read kick cycle, 3 draining.
  int             m_phase = 0;
  int             m_acc   = 0;
  int             m_read  = 0;
  int             m_tie   = 0;          // requester that wins a tie
  bit             m_owner[BATCH];
  bit             m_err = 0;
  bit             m_rv = 0, m_bd = 0, m_ro = 0;
  logic [RW-1:0]  m_rd = '0;
  int             m_ri = 0;

  task automatic m_reset();
    m_phase = 0; m_acc = 0; m_read = 0; m_tie = 0; m_err = 0;
    m_rv = 0; m_bd = 0; m_ro = 0; m_rd = '0; m_ri = 0;
  endtask

  function automatic bit m_eligible();
    return (m_phase == 0) && RDY_mac && (req0_valid || req1_valid);
  endfunction

  function automatic int m_grant();
    if (req0_valid && !req1_valid) return 0;
    if (req1_valid && !req0_valid) return 1;
    return m_tie;
  endfunction

  always @(negedge RST_N) m_reset();

  // Advance the model on each rising edge using the inputs the DUT sees.
  always @(posedge CLK) begin
    if (RST_N) begin
      bit el;
      int g;
      bit nrv, nbd;
      el  = m_eligible();
      g   = m_grant();
      nrv = 0;
      nbd = 0;
      if (VALID_memVal && m_phase != 3) m_err = 1;
      case (m_phase)
        0: if (el) begin
          m_owner[m_acc] = g[0];
          m_tie = 1 - g;
          m_acc++;
          if (m_acc == BATCH) m_phase = 1;
        end
        1: if (RDY_blockRead) m_phase = 2;
        2: m_phase = 3;
        default: if (VALID_memVal) begin
          nrv  = 1;
          m_rd = memVal_data;
          m_ri = m_read;
          m_ro = m_owner[m_read];
          m_read++;
          if (m_read == BATCH) begin
            nbd = 1; m_read = 0; m_acc = 0; m_phase = 0;
          end
        end
      endcase
      m_rv = nrv;
      m_bd = nbd;
    end
  end

  // ---------------- monitor counters for directed checks ----------------
  int fires_seen = 0, rd_pulses = 0, bd_seen = 0, busy_ready = 0, gnt1_cnt = 0;
  int gnt_log[$];
  int ridx_log[$];
  logic [RW-1:0] rdata_log[$];
  int rown_log[$];

  task automatic clr_mon();
    fires_seen = 0; rd_pulses = 0; bd_seen = 0; busy_ready = 0; gnt1_cnt = 0;
    gnt_log.delete(); ridx_log.delete(); rdata_log.delete(); rown_log.delete();
  endtask

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge CLK) begin
    if (!RST_N) begin
      check("rst_en_mac", EN_mac, 0);
      check("rst_ready", {req1_ready, req0_ready}, 0);
      check("rst_en_blockread", EN_blockRead, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_batch_done", batch_done, 0);
      check("rst_err", err_spurious, 0);
      check("rst_res_fields", {res_data, res_idx, res_owner}, 0);
    end else begin
      bit el;
      int g;
      logic [4*DW-1:0] ea, eb;
      el = m_eligible();
      g  = m_grant();
      ea = (g == 1) ? req1_vect_a : req0_vect_a;
      eb = (g == 1) ? req1_vect_b : req0_vect_b;
      check("en_mac", EN_mac, el);
      check("req0_ready", req0_ready, el && g == 0);
      check("req1_ready", req1_ready, el && g == 1);
      if (el) begin
        check("vect_a", {mac_vectA_3, mac_vectA_2, mac_vectA_1, mac_vectA_0}, ea);
        check("vect_b", {mac_vectB_3, mac_vectB_2, mac_vectB_1, mac_vectB_0}, eb);
      end
      check("en_blockread", EN_blockRead, m_phase == 2);
      check("res_valid", res_valid, m_rv);
      check("batch_done", batch_done, m_bd);
      check("err_spurious", err_spurious, m_err);
      if (m_rv) begin
        check("res_data", res_data, m_rd);
        check("res_idx", res_idx, m_ri);
        check("res_owner", res_owner, m_ro);
      end
      if (EN_mac) begin
        fires_seen++;
        gnt_log.push_back(int'(req1_ready));
        if (req1_ready) gnt1_cnt++;
      end
      if (!RDY_mac && (req0_ready || req1_ready)) busy_ready++;
      if (EN_blockRead) rd_pulses++;
      if (batch_done) bd_seen++;
      if (res_valid) begin
        ridx_log.push_back(int'(res_idx));
        rdata_log.push_back(res_data);
        rown_log.push_back(int'(res_owner));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_vects();
    req0_vect_a = {$urandom, $urandom};
    req0_vect_b = {$urandom, $urandom};
    req1_vect_a = {$urandom, $urandom};
    req1_vect_b = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    cyc();
    RST_N = 1'b0;
    #1;
    check("rst_now_en_mac", EN_mac, 0);
    check("rst_now_ready", {req1_ready, req0_ready}, 0);
    check("rst_now_outs", {res_valid, batch_done, err_spurious, EN_blockRead}, 0);
    check("rst_now_data", {res_data, res_idx, res_owner}, 0);
    cyc();
    cyc();
    RST_N = 1'b1;
    clr_mon();
  endtask

  // Waits for the read kick after `hold` cycles of not-readable, then feeds 64 beats.
  // mode 0: data = index, 1: random data with random gaps.
  task automatic readout(input int hold, input int mode);
    int guard;
    RDY_blockRead = 1'b0;
    repeat (hold) cyc();
    check("no_early_blockread", rd_pulses, 0);
    RDY_blockRead = 1'b1;
    guard = 0;
    while (rd_pulses == 0 && guard < 50) begin
      cyc();
      guard++;
    end
    check("blockread_seen", rd_pulses, 1);
    RDY_blockRead = 1'b0;
    for (int k = 0; k < BATCH; k++) begin
      VALID_memVal = 1'b1;
      memVal_data  = (mode == 0) ? RW'(k) : {$urandom, $urandom};
      cyc();
      VALID_memVal = 1'b0;
      if (mode == 1) repeat ($urandom_range(0, 2)) cyc();
    end
    repeat (3) cyc();
    check("blockread_once", rd_pulses, 1);
    check("batch_done_once", bd_seen, 1);
    check("result_count", ridx_log.size(), BATCH);
  endtask

  initial begin
    // A: lone requester 0 fills the whole batch, then a delayed readout of 0..63.
    do_reset();
    req0_valid = 1'b1;
    RDY_mac    = 1'b1;
    for (int i = 0; i < BATCH; i++) begin
      rand_vects();
      cyc();
    end
    repeat (3) cyc();
    check("a_fires", fires_seen, 64);
    check("a_gnt1", gnt1_cnt, 0);
    check("a_no_fire_after_fill", EN_mac, 0);
    req0_valid = 1'b0;
    readout(20, 0);
    for (int k = 0; k < ridx_log.size(); k++) begin
      check("a_idx_seq", ridx_log[k], k);
      check("a_data_seq", rdata_log[k], k);
    end

    // B: both requesters always valid -> strict alternation from requester 0.
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    RDY_mac    = 1'b1;
    for (int i = 0; i < BATCH; i++) begin
      rand_vects();
      cyc();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("b_fires", fires_seen, 64);
    for (int i = 0; i < gnt_log.size(); i++) check("b_alt", gnt_log[i], i % 2);
    readout(2, 1);
    for (int k = 0; k < ridx_log.size(); k++) check("b_owner_parity", rown_log[k], ridx_log[k] % 2);

    // C/D: RDY_mac toggles every cycle; a stray read-back beat during fill.
    do_reset();
    req0_valid = 1'b1;
    for (int i = 0; i < 2 * BATCH + 4; i++) begin
      RDY_mac = i[0];
      VALID_memVal = (i == 5);
      memVal_data  = 34'h2_dead_beef;
      rand_vects();
      cyc();
    end
    VALID_memVal = 1'b0;
    RDY_mac      = 1'b0;
    req0_valid   = 1'b0;
    check("c_fires", fires_seen, 64);
    check("c_busy_ready", busy_ready, 0);
    check("d_err_set", err_spurious, 1);
    check("d_no_result", ridx_log.size(), 0);
    readout(0, 1);
    check("d_err_sticky", err_spurious, 1);

    // E: reset after 30 fires with inputs still active, then a full fresh batch.
    do_reset();
    RDY_mac = 1'b1;
    for (int i = 0; i < 30; i++) begin
      req0_valid = $urandom_range(0, 1);
      req1_valid = !req0_valid || ($urandom_range(0, 1) == 1);
      rand_vects();
      cyc();
    end
    check("e_fires_before_reset", fires_seen, 30);
    do_reset();
    for (int i = 0; i < BATCH; i++) begin
      req0_valid = $urandom_range(0, 1);
      req1_valid = !req0_valid || ($urandom_range(0, 1) == 1);
      rand_vects();
      cyc();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("e_fires_after_reset", fires_seen, 64);
    readout(1, 1);
    check("e_first_idx", (ridx_log.size() > 0) ? ridx_log[0] : -1, 0);

    // Random traffic on every input for three batches.
    do_reset();
    begin
      int cycles = 0;
      while (bd_seen < 3 && cycles < 6000) begin
        req0_valid    = ($urandom_range(0, 3) != 0);
        req1_valid    = ($urandom_range(0, 1) != 0);
        RDY_mac       = ($urandom_range(0, 3) != 0);
        RDY_blockRead = ($urandom_range(0, 2) == 0);
        VALID_memVal  = ($urandom_range(0, 2) != 0);
        memVal_data   = {$urandom, $urandom};
        rand_vects();
        cyc();
        cycles++;
      end
      VALID_memVal = 1'b0;
      check("rand_batches", bd_seen, 3);
    end
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
